// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore state register, combinational decode
// of datapath enables and ALU operation from the current state.
module mips_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] aluOp,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   pc_write;
    logic   branch;
    logic   fn_ok;
    logic [2:0] fn_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= state_t'(RESET_STATE);
        else        state_q <= state_d;
    end

    always_comb begin
        fn_ok  = 1'b1;
        fn_alu = 3'b010;
        case (funct)
            6'b100000: fn_alu = 3'b010;
            6'b100010: fn_alu = 3'b110;
            6'b100100: fn_alu = 3'b000;
            6'b100101: fn_alu = 3'b001;
            6'b101010: fn_alu = 3'b111;
            default:   fn_ok  = 1'b0;
        endcase
    end

    always_comb begin
        aluOp      = 3'b010;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        state_d    = S_FETCH;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (op == OP_LW || op == OP_SW)
                    state_d = S_MEMADR;
                else if (op == OP_RTYPE && fn_ok)
                    state_d = S_EXECUTE;
                else if (op == OP_BEQ)
                    state_d = S_BRANCH;
                else if (op == OP_ADDI)
                    state_d = S_ADDIEX;
                else if (op == OP_J)
                    state_d = S_JUMP;
                else
                    illegal = 1'b1;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                aluOp     = fn_alu;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluOp     = 3'b110;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            // codes 12-15: recover to fetch and flag it
            default: illegal = 1'b1;
        endcase
    end

    assign pc_en = pc_write | (branch & zero);
    assign state = state_q;

endmodule
